// File: rtl/formic_bctl_trace_in_rec_if.sv
// Trace-input handshake bundle for formic_bctl_trace_in_rec.
// The master drives trace words and read/clear controls; the slave is the buffer.
interface formic_bctl_trace_in_rec_if #(
  parameter int DW    = 8,
  parameter int AW    = 6,
  parameter int CNT_W = 16
);
  logic [DW-1:0]    i_data;
  logic             i_valid;
  logic             i_deq;
  logic             i_clr_drops;
  logic [DW-1:0]    o_data;
  logic             o_data_valid;
  logic             o_rec_avail;
  logic [AW:0]      o_words;
  logic             o_drop;
  logic [CNT_W-1:0] o_drop_cnt;

  modport master (
    output i_data, i_valid, i_deq, i_clr_drops,
    input  o_data, o_data_valid, o_rec_avail, o_words, o_drop, o_drop_cnt
  );
  modport slave (
    input  i_data, i_valid, i_deq, i_clr_drops,
    output o_data, o_data_valid, o_rec_avail, o_words, o_drop, o_drop_cnt
  );
endinterface

// File: rtl/formic_bctl_trace_in_rec.sv
// Record-granular trace input FIFO: whole records are admitted or dropped,
// and readers only ever see committed (complete) records.
module formic_bctl_trace_in_rec #(
  parameter int DW      = 8,
  parameter int REC_LEN = 8,
  parameter int DEPTH   = 64,
  parameter int AW      = 6,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic rst,
  formic_bctl_trace_in_rec_if.slave tif
);
  localparam int CW = (REC_LEN > 1) ? $clog2(REC_LEN) : 1;

  typedef enum logic [2:0] {IDLE = 3'b001, ENQ = 3'b010, DROP = 3'b100} state_t;

  state_t        state;
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, cm_ptr, rd_ptr, used, free, words;
  logic [CW-1:0] in_cnt;
  logic          last, room, admit, drop_dec, wr_en, deq;

  // Admission looks only at registered pointers; a same-cycle deq is not credited.
  always_comb begin
    used     = wr_ptr - rd_ptr;
    free     = (AW+1)'(DEPTH) - used;
    room     = free >= (AW+1)'(REC_LEN);
    last     = in_cnt == CW'(REC_LEN - 1);
    admit    = tif.i_valid && (state == IDLE) && room;
    drop_dec = tif.i_valid && (state == IDLE) && !room;
    wr_en    = admit || (tif.i_valid && (state == ENQ));
    words    = cm_ptr - rd_ptr;
    deq      = tif.i_deq && (words != '0);
  end

  assign tif.o_data       = mem[rd_ptr[AW-1:0]];
  assign tif.o_words      = words;
  assign tif.o_data_valid = words != '0;
  assign tif.o_rec_avail  = words >= (AW+1)'(REC_LEN);

  // in_cnt tracks record framing regardless of admit/drop, so the FSM
  // always returns to IDLE exactly on a record boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      in_cnt <= '0;
    end else if (tif.i_valid) begin
      in_cnt <= last ? '0 : in_cnt + CW'(1);
      if (last)               state <= IDLE;
      else if (state == IDLE) state <= room ? ENQ : DROP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      cm_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (last) cm_ptr <= wr_ptr + 1'b1;
      end
      if (deq) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= tif.i_data;
  end

  // Set beats a same-cycle clear, and clear-with-increment yields 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tif.o_drop     <= 1'b0;
      tif.o_drop_cnt <= '0;
    end else begin
      if (drop_dec) tif.o_drop <= 1'b1;
      else if (deq) tif.o_drop <= 1'b0;
      if (tif.i_clr_drops)
        tif.o_drop_cnt <= drop_dec ? CNT_W'(1) : '0;
      else if (drop_dec && (tif.o_drop_cnt != '1))
        tif.o_drop_cnt <= tif.o_drop_cnt + 1'b1;
    end
  end
endmodule
